id_stage: RTL and testbench

Instruction-decode stage sitting directly downstream of the instruction memory. It latches the 16-bit instruction word each clock, reads a 16×16 register file, and decodes the opcode into control signals for execute. It resolves `bne` and `j` itself, driving the branch-enable and branch-address inputs of the instruction memory. It also squashes the one wrong-path instruction fetched behind a taken branch.

---
 rtl/id_pkg.sv | 26 ++
 rtl/regfile.sv | 42 ++++
 rtl/id_stage.sv | 113 +++++++++++
 tb/tb_id_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared constants for the instruction-decode stage: opcodes, instruction
// field positions and default datapath sizing.
package id_pkg;

   localparam int DW_DEF   = 16;
   localparam int NREG_DEF = 16;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BNE  = 4'h6;
   localparam logic [3:0] OP_J    = 4'h7;

   localparam int OP_LSB = 12;
   localparam int F3_LSB = 8;
   localparam int F2_LSB = 4;
   localparam int F1_LSB = 0;

   function automatic logic [3:0] field(input logic [15:0] word, input int lsb);
      return word[lsb +: 4];
   endfunction

endpackage

// File: rtl/regfile.sv
// Two-read / one-write register file with R0 hardwired to zero and a
// same-cycle write-to-read bypass.
module regfile #(
   parameter int DW   = 16,
   parameter int NREG = 16,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] ra_data,
   output logic [DW-1:0] rb_data
);

   logic [DW-1:0] regs [NREG];

   // NOTE: the register array is reset because decode must read zeros
   // after reset; the loop maps onto per-register synchronous clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_en && wb_addr != '0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // A nonzero read index matching the live write index can only be a
   // genuine write, so the bypass needs no separate R0 check.
   always_comb begin
      ra_data = regs[ra_addr];
      rb_data = regs[rb_addr];
      if (ra_addr == '0)                  ra_data = '0;
      else if (wb_en && wb_addr == ra_addr) ra_data = wb_data;
      if (rb_addr == '0)                  rb_data = '0;
      else if (wb_en && wb_addr == rb_addr) rb_data = wb_data;
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: latches the fetched word, reads operands, decodes controls,
// resolves bne/j and squashes the single wrong-path slot behind a taken branch.
module id_stage
   import id_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   IIn,
   output logic          BE,
   output logic [3:0]    BranchADR,
   input  logic          wb_en,
   input  logic [3:0]    wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          ex_valid,
   output logic [3:0]    ex_op,
   output logic [3:0]    ex_rd,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [DW-1:0] ex_sdata,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          illegal,
   output logic [7:0]    squash_cnt
);

   logic [15:0]   ir;
   logic          vld;
   logic [3:0]    op, f3, f2, f1, rb_sel;
   logic [DW-1:0] ra_data, rb_data, imm;

   assign op  = field(ir, OP_LSB);
   assign f3  = field(ir, F3_LSB);
   assign f2  = field(ir, F2_LSB);
   assign f1  = field(ir, F1_LSB);
   assign imm = {{(DW-4){1'b0}}, f1};

   // Port A always reads f2; port B reads f1 for reg-reg ALU ops, else f3.
   assign rb_sel = (op == OP_SUB || op == OP_AND) ? f1 : f3;

   regfile #(.DW(DW), .NREG(NREG), .AW(4)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .ra_addr (f2),
      .rb_addr (rb_sel),
      .ra_data (ra_data),
      .rb_data (rb_data)
   );

   // NOTE: every output is given a default before the case so no latch is inferred.
   always_comb begin
      BE          = 1'b0;
      BranchADR   = '0;
      ex_valid    = vld;
      ex_op       = '0;
      ex_rd       = '0;
      ex_a        = '0;
      ex_b        = '0;
      ex_sdata    = '0;
      ex_regwrite = 1'b0;
      ex_memread  = 1'b0;
      ex_memwrite = 1'b0;
      if (vld) begin
         ex_op = op;
         case (op)
            OP_NOP: ;
            OP_ADDI: begin
               ex_rd = f3; ex_a = ra_data; ex_b = imm; ex_regwrite = 1'b1;
            end
            OP_SUB, OP_AND: begin
               ex_rd = f3; ex_a = ra_data; ex_b = rb_data; ex_regwrite = 1'b1;
            end
            OP_LW: begin
               ex_rd = f3; ex_a = ra_data; ex_b = imm;
               ex_memread = 1'b1; ex_regwrite = 1'b1;
            end
            OP_SW: begin
               ex_a = ra_data; ex_b = imm; ex_sdata = rb_data; ex_memwrite = 1'b1;
            end
            OP_BNE: begin
               BE = (rb_data != ra_data); BranchADR = f1;
            end
            OP_J: begin
               BE = 1'b1; BranchADR = f1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them
   // sample the pre-edge values of BE, vld and op.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir         <= '0;
         vld        <= 1'b0;
         illegal    <= 1'b0;
         squash_cnt <= '0;
      end else begin
         ir  <= IIn;
         vld <= !BE;
         if (vld && op[3])                 illegal    <= 1'b1;
         if (BE && squash_cnt != 8'hFF)    squash_cnt <= squash_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, branch/squash, bypass,
// illegal flag, squash counter saturation and mid-stream reset.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] IIn;
   logic        BE;
   logic [3:0]  BranchADR;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        ex_valid;
   logic [3:0]  ex_op, ex_rd;
   logic [15:0] ex_a, ex_b, ex_sdata;
   logic        ex_regwrite, ex_memread, ex_memwrite;
   logic        illegal;
   logic [7:0]  squash_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk         (clk),
      .reset       (reset),
      .IIn         (IIn),
      .BE          (BE),
      .BranchADR   (BranchADR),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ex_valid    (ex_valid),
      .ex_op       (ex_op),
      .ex_rd       (ex_rd),
      .ex_a        (ex_a),
      .ex_b        (ex_b),
      .ex_sdata    (ex_sdata),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_memwrite (ex_memwrite),
      .illegal     (illegal),
      .squash_cnt  (squash_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; IIn = 16'h7005; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      step(); step();
      check("rst_be",       BE,         0);
      check("rst_badr",     BranchADR,  0);
      check("rst_valid",    ex_valid,   0);
      check("rst_squash",   squash_cnt, 0);
      check("rst_illegal",  illegal,    0);
      check("rst_a",        ex_a,       0);

      // addi R1, R0, 5
      reset = 1'b0; IIn = 16'h1105;
      step();
      check("addi_valid", ex_valid,    1);
      check("addi_op",    ex_op,       1);
      check("addi_rd",    ex_rd,       1);
      check("addi_a",     ex_a,        0);
      check("addi_b",     ex_b,        5);
      check("addi_rw",    ex_regwrite, 1);
      check("addi_be",    BE,          0);

      // writeback R1 = 5, then R4 = 3
      IIn = 16'h0000; wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'd5;
      step();
      wb_addr = 4'd4; wb_data = 16'd3;
      step();

      // bne R1, R4 -> 0xC (taken)
      wb_en = 1'b0; IIn = 16'h614C;
      step();
      check("bne_t_be",    BE,          1);
      check("bne_t_badr",  BranchADR,   4'hC);
      check("bne_t_valid", ex_valid,    1);
      IIn = 16'h1111;
      step();
      check("sq_valid",  ex_valid,    0);
      check("sq_rw",     ex_regwrite, 0);
      check("sq_rd",     ex_rd,       0);
      check("sq_be",     BE,          0);
      check("sq_cnt1",   squash_cnt,  1);

      // bne R1, R1 (not taken)
      IIn = 16'h6110;
      step();
      check("bne_n_valid", ex_valid,   1);
      check("bne_n_be",    BE,         0);
      IIn = 16'h0000;
      step();
      check("bne_n_next_valid", ex_valid,   1);
      check("bne_n_cnt",        squash_cnt, 1);

      // j 0xA followed by j 0x3 in the squashed slot
      IIn = 16'h700A;
      step();
      check("j1_be",   BE,        1);
      check("j1_badr", BranchADR, 4'hA);
      IIn = 16'h7003;
      step();
      check("j2_be",    BE,         0);
      check("j2_valid", ex_valid,   0);
      check("j2_cnt",   squash_cnt, 2);
      IIn = 16'h0000;
      step();
      check("j_after_valid", ex_valid, 1);
      check("j_after_be",    BE,       0);

      // bypass: sub R3, R2, R0 while R2 <= 0x1234 is written
      IIn = 16'h2320;
      step();
      wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h1234;
      #1;
      check("byp_a",  ex_a,        16'h1234);
      check("byp_b",  ex_b,        0);
      check("byp_rd", ex_rd,       3);
      check("byp_rw", ex_regwrite, 1);

      // addi R0, R0, 7 while writing 0xFFFF to R0
      IIn = 16'h1007;
      step();
      wb_addr = 4'd0; wb_data = 16'hFFFF;
      #1;
      check("r0_wr_a", ex_a, 0);
      IIn = 16'h2020;
      step();
      wb_en = 1'b0;
      #1;
      check("r0_after_b",  ex_b, 0);
      check("r2_stored_a", ex_a, 16'h1234);

      // illegal opcode in squashed slot, then in a live slot
      IIn = 16'h7005;
      step();
      check("j3_be", BE, 1);
      IIn = 16'h8000;
      step();
      check("ill_sq_valid", ex_valid,   0);
      check("ill_sq_cnt",   squash_cnt, 3);
      IIn = 16'h9000;
      step();
      check("ill_sq_flag",  illegal,     0);
      check("ill_valid",    ex_valid,    1);
      check("ill_rw",       ex_regwrite, 0);
      IIn = 16'h0000;
      step();
      check("ill_set", illegal, 1);
      step();
      check("ill_sticky", illegal, 1);

      // back-to-back j stream: each pair squashes one slot
      IIn = 16'h7000;
      for (int i = 0; i < 520; i++) step();
      check("sat_cnt",   squash_cnt, 8'hFF);
      check("sat_valid", ex_valid,   0);
      step();
      check("sat_j_be", BE, 1);
      step();
      check("sat_hold", squash_cnt, 8'hFF);
      step();
      check("pre_rst_be", BE, 1);

      // reset with a taken branch pending
      IIn = 16'h7002; reset = 1'b1;
      step();
      check("mrst_be",      BE,         0);
      check("mrst_valid",   ex_valid,   0);
      check("mrst_cnt",     squash_cnt, 0);
      check("mrst_illegal", illegal,    0);
      check("mrst_badr",    BranchADR,  0);

      // first instruction after release is live; R1 was cleared
      reset = 1'b0; IIn = 16'h1210;
      step();
      check("post_valid", ex_valid,    1);
      check("post_rd",    ex_rd,       2);
      check("post_a",     ex_a,        0);
      check("post_rw",    ex_regwrite, 1);
      check("post_cnt",   squash_cnt,  0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
